// File: rtl/gxc_pkg.sv
// ============================================================================
// gxc_pkg : shared constants, FIFO entry type and grant decode helper
// Rev 1.0
// ============================================================================
`default_nettype none

package gxc_pkg;

  localparam int NUM_REQ    = 4;
  localparam int SRC_W      = 2;
  localparam int DATA_W_DFLT = 8;

  // Default-width entry; the top re-declares it at its own DATA_W.
  typedef struct packed {
    logic [SRC_W-1:0]       src;
    logic [DATA_W_DFLT-1:0] data;
  } gxc_entry_t;

  function automatic logic [SRC_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [SRC_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = idx | SRC_W'(i);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gxc_fifo.sv
// ============================================================================
// gxc_fifo : DEPTH-entry FIFO with head hold when empty
// Rev 1.0
// ============================================================================
`default_nettype none

module gxc_fifo
  import gxc_pkg::*;
#(
  parameter type entry_t = gxc_entry_t,
  parameter int  DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  entry_t                   push_entry,
  input  logic                     pop,
  output entry_t                   head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  entry_t             r_mem [DEPTH];
  entry_t             r_last;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W:0]     r_count;
  logic               w_push;
  logic               w_pop;

  assign full  = (r_count == (PTR_W+1)'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Once drained, the head keeps showing the last entry that left.
  assign head = empty ? r_last : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push && !rst) r_mem[r_wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_last   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_last   <= r_mem[r_rd_ptr];
      end
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/grant_xfer_ctrl.sv
// ============================================================================
// grant_xfer_ctrl : captures one-hot arbiter grants into an output FIFO.
// Optional transfer counter enabled by macro GXC_STATS_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module grant_xfer_ctrl
  import gxc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        grant,
  input  logic [NUM_REQ*DATA_W-1:0] data_in,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [SRC_W-1:0]          out_src,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      err,
  output logic [15:0]               xfer_cnt
);

  typedef struct packed {
    logic [SRC_W-1:0]  src;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic [NUM_REQ-1:0] w_grant_low;
  logic               w_multi_hot;
  logic               w_one_hot;
  logic [SRC_W-1:0]   w_idx;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  entry_t             w_push_entry;
  entry_t             w_head;
  logic               r_err;

  // Clearing the lowest set bit leaves nonzero only for multi-hot grants.
  assign w_grant_low = grant & (grant - 1'b1);
  assign w_multi_hot = (w_grant_low != '0);
  assign w_one_hot   = (grant != '0) && !w_multi_hot;
  assign w_idx       = onehot_to_idx(grant);

  assign w_push = !rst && w_one_hot && !w_full;
  assign w_pop  = !rst && !w_empty && out_ready;
  assign ack    = w_push ? grant : '0;

  assign w_push_entry.src  = w_idx;
  assign w_push_entry.data = data_in[w_idx*DATA_W +: DATA_W];

  gxc_fifo #(
    .entry_t (entry_t),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (w_push),
    .push_entry (w_push_entry),
    .pop        (w_pop),
    .head       (w_head),
    .full       (w_full),
    .empty      (w_empty),
    .count      (count)
  );

  assign out_valid = !w_empty;
  assign out_data  = w_head.data;
  assign out_src   = w_head.src;

  always_ff @(posedge clk) begin
    if (rst)              r_err <= 1'b0;
    else if (w_multi_hot) r_err <= 1'b1;
  end
  assign err = r_err;

`ifdef GXC_STATS_EN
  logic [15:0] r_xfer_cnt;
  always_ff @(posedge clk) begin
    if (rst)                                  r_xfer_cnt <= '0;
    else if (w_pop && r_xfer_cnt != 16'hFFFF) r_xfer_cnt <= r_xfer_cnt + 1'b1;
  end
  assign xfer_cnt = r_xfer_cnt;
`else
  assign xfer_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_grant_xfer_ctrl.sv
// ============================================================================
// tb_grant_xfer_ctrl : scoreboard bench for grant_xfer_ctrl (DATA_W=8, DEPTH=4)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_grant_xfer_ctrl;

  logic        clk;
  logic        rst;
  logic [3:0]  grant;
  logic [31:0] data_in;
  logic [3:0]  ack;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_src;
  logic [2:0]  count;
  logic        err;
  logic [15:0] xfer_cnt;

  typedef struct packed {
    logic [1:0] src;
    logic [7:0] data;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

`ifdef GXC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  grant_xfer_ctrl #(.DATA_W(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .grant     (grant),
    .data_in   (data_in),
    .ack       (ack),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .count     (count),
    .err       (err),
    .xfer_cnt  (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] src_of(input logic [3:0] g);
    case (g)
      4'b0001: return 2'd0;
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  task automatic drive(input logic [3:0] g, input logic [7:0] d, input logic rdy);
    grant     = g;
    out_ready = rdy;
    data_in   = $urandom;
    for (int i = 0; i < 4; i++) if (g[i]) data_in[i*8 +: 8] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(4'b0000, 8'h00, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(4'b0010, 8'h5A, 1'b1);
    #1;
    checks++;
    if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack: got %b want 0000", ack); end
    @(posedge clk); #1;
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || out_data !== 8'h00 || out_src !== 2'd0 ||
        err !== 1'b0 || xfer_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: cnt=%0d vld=%b data=%h src=%0d err=%b xfer=%0d want all 0",
               count, out_valid, out_data, out_src, err, xfer_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    q.delete();
  endtask

  task automatic test_single();
    exp_t e;
    do_reset();
    drive(4'b0010, 8'hA5, 1'b0);
    #1;
    checks++;
    if (ack !== 4'b0010) begin errors++; $display("FAIL single_ack: got %b want 0010", ack); end
    q.push_back('{src: 2'd1, data: 8'hA5});
    @(posedge clk); #1;
    e = q[0];
    checks++;
    if (out_valid !== 1'b1 || out_data !== e.data || out_src !== e.src || count !== 3'd1) begin
      errors++;
      $display("FAIL single_head: vld=%b data=%h src=%0d cnt=%0d want 1 %h %0d 1",
               out_valid, out_data, out_src, count, e.data, e.src);
    end
    @(negedge clk);
    drive(4'b0000, 8'h00, 1'b1);
    @(posedge clk); #1;
    e = q.pop_front();
    checks++;
    if (out_valid !== 1'b0 || count !== 3'd0 || out_data !== e.data || out_src !== e.src) begin
      errors++;
      $display("FAIL empty_hold: vld=%b cnt=%0d data=%h src=%0d want 0 0 %h %0d",
               out_valid, count, out_data, out_src, e.data, e.src);
    end
  endtask

  task automatic test_fill_drain();
    exp_t       e;
    logic [3:0] g;
    logic [7:0] d;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      g = 4'b0001 << i;
      d = 8'($urandom);
      drive(g, d, 1'b0);
      #1;
      checks++;
      if (ack !== g) begin errors++; $display("FAIL fill_ack%0d: got %b want %b", i, ack, g); end
      q.push_back('{src: src_of(g), data: d});
      @(posedge clk); #1;
      checks++;
      if (count !== 3'(i + 1)) begin errors++; $display("FAIL fill_count%0d: got %0d want %0d", i, count, i + 1); end
      @(negedge clk);
    end
    drive(4'b0001, 8'h3C, 1'b0);
    #1;
    checks++;
    if (ack !== 4'b0000) begin errors++; $display("FAIL full_ack: got %b want 0000", ack); end
    @(posedge clk); #1;
    checks++;
    if (count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d want 4", count); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(4'b0000, 8'h00, 1'b1);
      #1;
      e = q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out_src !== e.src || out_data !== e.data || out_src !== 2'(i)) begin
        errors++;
        $display("FAIL drain%0d: vld=%b src=%0d data=%h want 1 %0d %h", i, out_valid, out_src, out_data, e.src, e.data);
      end
      @(posedge clk);
    end
    #1;
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL drain_empty: cnt=%0d vld=%b want 0 0", count, out_valid);
    end
  endtask

  task automatic test_full_pop();
    exp_t       e;
    logic [3:0] g;
    logic [7:0] d;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      g = 4'b1000 >> i;
      d = 8'($urandom);
      drive(g, d, 1'b0);
      q.push_back('{src: src_of(g), data: d});
      @(negedge clk);
    end
    drive(4'b0001, 8'h77, 1'b1);
    #1;
    e = q.pop_front();
    checks++;
    if (ack !== 4'b0000 || out_src !== e.src || out_data !== e.data) begin
      errors++;
      $display("FAIL fullpop_ack: ack=%b src=%0d data=%h want 0000 %0d %h", ack, out_src, out_data, e.src, e.data);
    end
    @(posedge clk); #1;
    checks++;
    if (count !== 3'd3) begin errors++; $display("FAIL fullpop_count: got %0d want 3", count); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(4'b0000, 8'h00, 1'b1);
      #1;
      e = q.pop_front();
      checks++;
      if (out_src !== e.src || out_data !== e.data) begin
        errors++; $display("FAIL fullpop_drain%0d: src=%0d data=%h want %0d %h", i, out_src, out_data, e.src, e.data);
      end
      @(posedge clk);
    end
  endtask

  task automatic test_back_to_back();
    exp_t       e;
    logic [3:0] g;
    logic [7:0] d;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      g = 4'b0100 >> i;
      d = 8'($urandom);
      drive(g, d, 1'b0);
      q.push_back('{src: src_of(g), data: d});
      @(negedge clk);
    end
    for (int i = 0; i < 10; i++) begin
      g = 4'b0001 << (i % 4);
      d = 8'($urandom);
      drive(g, d, 1'b1);
      #1;
      e = q.pop_front();
      checks++;
      if (ack !== g || out_src !== e.src || out_data !== e.data) begin
        errors++;
        $display("FAIL b2b%0d: ack=%b src=%0d data=%h want %b %0d %h", i, ack, out_src, out_data, g, e.src, e.data);
      end
      q.push_back('{src: src_of(g), data: d});
      @(posedge clk); #1;
      checks++;
      if (count !== 3'd2) begin errors++; $display("FAIL b2b_count%0d: got %0d want 2", i, count); end
      @(negedge clk);
    end
    for (int i = 0; i < 2; i++) begin
      drive(4'b0000, 8'h00, 1'b1);
      #1;
      e = q.pop_front();
      checks++;
      if (out_src !== e.src || out_data !== e.data) begin
        errors++; $display("FAIL b2b_tail%0d: src=%0d data=%h want %0d %h", i, out_src, out_data, e.src, e.data);
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_multihot();
    do_reset();
    drive(4'b0000, 8'h00, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (err !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL idle_err: err=%b cnt=%0d want 0 0", err, count); end
    @(negedge clk);
    drive(4'b0011, 8'hEE, 1'b0);
    #1;
    checks++;
    if (ack !== 4'b0000) begin errors++; $display("FAIL multi_ack: got %b want 0000", ack); end
    @(posedge clk); #1;
    checks++;
    if (err !== 1'b1 || count !== 3'd0) begin errors++; $display("FAIL multi_err: err=%b cnt=%0d want 1 0", err, count); end
    @(negedge clk);
    drive(4'b0001, 8'h11, 1'b1);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      drive(4'b0000, 8'h00, 1'b1);
    end
    #1;
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", err); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", err); end
    @(negedge clk);
    rst = 1'b0;
    q.delete();
  endtask

  task automatic test_stats();
    logic [7:0] d;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom);
      drive(4'b0100, d, 1'b0);
      @(posedge clk);
      @(negedge clk);
      drive(4'b0000, 8'h00, 1'b1);
      @(posedge clk);
      @(negedge clk);
    end
    #1;
    checks++;
    if (xfer_cnt !== (STATS ? 16'd5 : 16'd0)) begin
      errors++; $display("FAIL xfer_cnt: got %0d want %0d", xfer_cnt, STATS ? 5 : 0);
    end
    drive(4'b0001, 8'h21, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(4'b1000, 8'h43, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    drive(4'b0010, 8'h65, 1'b1);
    #1;
    checks++;
    if (ack !== 4'b0000) begin errors++; $display("FAIL rst_mid_ack: got %b want 0000", ack); end
    @(posedge clk); #1;
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || xfer_cnt !== 16'd0 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid: cnt=%0d vld=%b xfer=%0d data=%h want 0 0 0 00", count, out_valid, xfer_cnt, out_data);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(4'b0000, 8'h00, 1'b0);
    q.delete();
  endtask

  initial begin
    rst = 1'b1;
    drive(4'b0000, 8'h00, 1'b0);
    test_reset();
    test_single();
    test_fill_drain();
    test_full_pop();
    test_back_to_back();
    test_multihot();
    test_stats();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/grant_xfer_ctrl.md
GRANT_XFER_CTRL -- requirements
Module: grant_xfer_ctrl

Interface
REQ-001 Parameter DATA_W, default 8; payload width per requester.
REQ-002 Parameter DEPTH, default 4; output FIFO entries, power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 grant  input  4  one-hot grant from the 4-way round-robin arbiter; 0000 = idle.
REQ-006 data_in  input  4*DATA_W  requester payloads; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-007 ack  output  4  combinational accept strobe; ack[i]=1 means requester i's payload was captured this cycle.
REQ-008 out_valid  output  1  FIFO head valid.
REQ-009 out_ready  input  1  downstream consumer ready.
REQ-010 out_data  output  DATA_W  FIFO head payload.
REQ-011 out_src  output  2  FIFO head source index, 0..3.
REQ-012 count  output  log2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
REQ-013 err  output  1  sticky illegal-grant flag.
REQ-014 xfer_cnt  output  16  completed-transfer counter (see Configuration).

Function
REQ-015 Push condition: grant is exactly one-hot AND count < DEPTH; on push, store {index(grant), data_in slice} at the tail in that same cycle.
REQ-016 ack = grant when the push condition holds, else 0000; zero-cycle latency from grant to ack.
REQ-017 Pop condition: out_valid AND out_ready; on pop, advance the head.
REQ-018 out_valid = (count != 0); out_data and out_src always reflect the head entry; when empty they hold their last values (0 after reset).
REQ-019 Grant-to-out_valid latency: 1 cycle when the FIFO is empty.
REQ-020 Full (count == DEPTH): push is blocked and ack = 0000, even if a pop occurs in the same cycle.
REQ-021 Simultaneous push and pop when 0 < count < DEPTH: count is unchanged, and entry order is preserved.
REQ-022 Pointers wrap modulo DEPTH; count never exceeds DEPTH and never underflows.
REQ-023 Multi-hot grant (popcount > 1): no push, ack = 0000, and err is set to 1 on the next edge; err stays set until rst.
REQ-024 grant = 0000: no push and no err; this is legal idle.
REQ-025 FIFO order is strictly first-in first-out; out_src identifies the originating requester of each entry.

Reset
REQ-026 When rst=1 at a clock edge: count=0, pointers=0, out_valid=0, out_data=0, out_src=0, err=0, xfer_cnt=0.
REQ-027 Reset during operation discards all FIFO contents; a push or pop in the reset cycle has no effect.
REQ-028 ack is forced to 0000 while rst=1.

Configuration
REQ-029 Macro GXC_STATS_EN defined: xfer_cnt increments by 1 on each pop and saturates at 16'hFFFF.
REQ-030 Macro GXC_STATS_EN undefined: the xfer_cnt port remains present, is tied to 0, and no counter logic is generated.

Structure
REQ-031 Package gxc_pkg holds NUM_REQ=4, SRC_W=2, the FIFO entry struct typedef {src, data}, and a onehot-to-index function.
REQ-032 Storage, pointers and count are implemented in sub-module gxc_fifo (push, pop, full, empty, count).
REQ-033 grant_xfer_ctrl keeps only grant decode, ack generation, err and statistics logic.

Verification
REQ-034 Reset, then grant=0010, data_in slice1=8'hA5, out_ready=0: ack=0010 in the same cycle; next cycle out_valid=1, out_data=A5, out_src=1, count=1.
REQ-035 Rotate grants 0001/0010/0100/1000 over 4 consecutive cycles with out_ready=0 (DEPTH=4): count reaches 4; a fifth grant gives ack=0000; then out_ready=1 drains the sources in order 0,1,2,3.
REQ-036 Full FIFO, grant=0001 together with out_ready=1: pop occurs, push is blocked, count goes 4->3, ack=0000.
REQ-037 count=2, push and pop in the same cycle for 10 cycles: count stays 2 and the output sequence matches the input order.
REQ-038 grant=0011: no push, ack=0000, err=1 next cycle; err remains 1 until rst pulses, then returns to 0.
REQ-039 GXC_STATS_EN defined, 5 pops: xfer_cnt=5; a mid-stream rst gives xfer_cnt=0 and count=0 on the next cycle.
